// File: rtl/div_restoring_seq.sv
// Sequential unsigned restoring divider for the ALU datapath.
// One quotient bit per clock; done pulse and divide-by-zero flag.
module div_restoring_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startdiv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shf;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             last;

  // Restore is implicit: a negative trial keeps the shifted value.
  always_comb begin
    shf    = {rem, dvd[WIDTH-1]};
    trial  = shf - {1'b0, dvs};
    qbit   = ~trial[WIDTH];
    rem_nx = qbit ? trial[WIDTH-1:0]
                  : shf[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], qbit};
    last   = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      div0  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (startdiv) begin
            if (b == '0) begin
              q    <= '1;
              r    <= a;
              div0 <= 1'b1;
              done <= 1'b1;
            end else begin
              dvd   <= a;
              dvs   <= b;
              rem   <= '0;
              quo   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          dvd <= dvd << 1;
          cnt <= cnt + CW'(1);
          if (last) begin
            q     <= quo_nx;
            r     <= rem_nx;
            div0  <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_restoring_seq.sv
// Bench for div_restoring_seq: directed boundaries plus random
// operands against an arithmetic reference model.
module tb_div_restoring_seq;

  logic       clk;
  logic       rst;
  logic       startdiv;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] q;
  logic [7:0] r;
  logic       busy;
  logic       done;
  logic       div0;

  int n_cmp = 0;
  int n_bad = 0;

  div_restoring_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .startdiv (startdiv),
    .a        (a),
    .b        (b),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .div0     (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_q(
    input logic [7:0] x,
    input logic [7:0] y
  );
    return (y == 0) ? 8'hFF : 8'(x / y);
  endfunction

  function automatic logic [7:0] ref_r(
    input logic [7:0] x,
    input logic [7:0] y
  );
    return (y == 0) ? x : 8'(x % y);
  endfunction

  // One-cycle start pulse; operands scrambled after acceptance.
  task automatic start(
    input logic [7:0] ta,
    input logic [7:0] tb
  );
    @(negedge clk);
    a = ta;
    b = tb;
    startdiv = 1'b1;
    @(negedge clk);
    startdiv = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic wait_done(
    input string      tag,
    input logic [7:0] ta,
    input logic [7:0] tb,
    input int         exp_busy
  );
    int nb  = 0;
    int cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busycyc"}, nb, exp_busy);
    check({tag, "_overlap"}, 32'(busy), 0);
    check({tag, "_q"}, 32'(q), 32'(ref_q(ta, tb)));
    check({tag, "_r"}, 32'(r), 32'(ref_r(ta, tb)));
    check({tag, "_div0"}, 32'(div0), 32'(tb == 0));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 0);
  endtask

  task automatic op(
    input string      tag,
    input logic [7:0] ta,
    input logic [7:0] tb
  );
    start(ta, tb);
    wait_done(tag, ta, tb, (tb == 0) ? 0 : 8);
  endtask

  initial begin
    int nd;
    int t;
    int prev;
    int seen;
    logic [7:0] ra;
    logic [7:0] rb;

    rst = 1'b0;
    startdiv = 1'b0;
    a = '0;
    b = '0;
    #12;
    check("rst_q", 32'(q), 0);
    check("rst_r", 32'(r), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_div0", 32'(div0), 0);
    @(negedge clk);
    rst = 1'b1;

    op("d200_7", 8'd200, 8'd7);
    op("d5_0", 8'd5, 8'd0);
    op("d255_1", 8'd255, 8'd1);
    op("d3_10", 8'd3, 8'd10);
    op("d0_9", 8'd0, 8'd9);
    op("d255_255", 8'd255, 8'd255);

    // Start pulsed mid-RUN must be ignored.
    start(8'd200, 8'd7);
    @(negedge clk);
    a = 8'd100;
    b = 8'd3;
    startdiv = 1'b1;
    @(negedge clk);
    startdiv = 1'b0;
    wait_done("ign", 8'd200, 8'd7, 6);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("ign_extra_done", nd, 0);

    // startdiv held high: periodic results.
    @(negedge clk);
    a = 8'd200;
    b = 8'd7;
    startdiv = 1'b1;
    t = 0;
    prev = -1;
    seen = 0;
    while (seen < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (done) begin
        check("hold_q", 32'(q), 28);
        check("hold_r", 32'(r), 4);
        if (prev >= 0) check("hold_period", t - prev, 10);
        prev = t;
        seen++;
      end
    end
    check("hold_seen", seen, 3);
    startdiv = 1'b0;
    repeat (15) @(negedge clk);

    // Reset during iteration 4 abandons the operation.
    start(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("arst_q", 32'(q), 0);
    check("arst_r", 32'(r), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_div0", 32'(div0), 0);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("arst_quiet", nd, 0);
    op("d50_6", 8'd50, 8'd6);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'd0
                                       : 8'($urandom);
      op("rnd", ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
